// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT-80 encryption core.
package present_pkg;

  localparam int PRESENT_BLOCK_W = 64;
  localparam int PRESENT_KEY_W   = 80;
  localparam int PRESENT_ROUNDS  = 31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } present_state_e;

endpackage

// File: rtl/key_addition.sv
// XOR of the cipher state with a 64-bit round key.
module key_addition (
  input  logic [63:0] state_in,
  input  logic [63:0] round_key,
  output logic [63:0] state_out
);

  assign state_out = state_in ^ round_key;

endmodule

// File: rtl/merge_0.sv
// Reassembles 16 nibbles into a 64-bit word; nibble 0 lands in bits [3:0].
module merge_0 (
  input  logic [15:0][3:0]  nib,
  output logic [63:0]       dout
);

  assign dout = nib;

endmodule

// File: rtl/perm.sv
// PRESENT bit permutation: bit i moves to 16*i mod 63, bit 63 stays put.
module perm (
  input  logic [63:0] din,
  output logic [63:0] dout
);

  for (genvar i = 0; i < 64; i++) begin : g_bit
    localparam int DST = (i == 63) ? 63 : ((i * 16) % 63);
    assign dout[DST] = din[i];
  end

endmodule

// File: rtl/present_key_update.sv
// One step of the PRESENT-80 key schedule for round counter rnd.
module present_key_update
  import present_pkg::*;
(
  input  logic [PRESENT_KEY_W-1:0] key_in,
  input  logic [4:0]               rnd,
  output logic [PRESENT_KEY_W-1:0] key_out
);

  logic [PRESENT_KEY_W-1:0] key_rot;
  logic [3:0]               top_sb;

  assign key_rot = {key_in[18:0], key_in[79:19]};

  sbox u_sbox (
    .din  (key_rot[79:76]),
    .dout (top_sb)
  );

  // Substituted top nibble, counter folded into bits [19:15].
  always_comb begin
    key_out         = key_rot;
    key_out[79:76]  = top_sb;
    key_out[19:15]  = key_rot[19:15] ^ rnd;
  end

endmodule

// File: rtl/sbox.sv
// PRESENT 4-bit substitution box.
module sbox (
  input  logic [3:0] din,
  output logic [3:0] dout
);

  // Table lookup of the PRESENT S-box.
  always_comb begin
    dout = 4'h0;
    case (din)
      4'h0: dout = 4'hC;
      4'h1: dout = 4'h5;
      4'h2: dout = 4'h6;
      4'h3: dout = 4'hB;
      4'h4: dout = 4'h9;
      4'h5: dout = 4'h0;
      4'h6: dout = 4'hA;
      4'h7: dout = 4'hD;
      4'h8: dout = 4'h3;
      4'h9: dout = 4'hE;
      4'hA: dout = 4'hF;
      4'hB: dout = 4'h8;
      4'hC: dout = 4'h4;
      4'hD: dout = 4'h7;
      4'hE: dout = 4'h1;
      4'hF: dout = 4'h2;
      default: dout = 4'h0;
    endcase
  end

endmodule

// File: rtl/split_0.sv
// Splits a 64-bit word into 16 nibbles; nibble 0 is bits [3:0].
module split_0 (
  input  logic [63:0]       din,
  output logic [15:0][3:0]  nib
);

  assign nib = din;

endmodule

// File: rtl/present_enc_core.sv
// Iterative PRESENT-80 encryption core, one round per clock.
//
// state | meaning
// IDLE  | waiting for a plaintext/key, in_ready high
// RUN   | executing rounds 1..ROUNDS, inputs ignored
// DONE  | ciphertext presented, held until out_ready
module present_enc_core
  import present_pkg::*;
#(
  parameter int ROUNDS = PRESENT_ROUNDS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PRESENT_BLOCK_W-1:0] in_pt,
  input  logic [PRESENT_KEY_W-1:0]   in_key,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PRESENT_BLOCK_W-1:0] out_ct
);

  localparam logic [4:0] LAST_RND = 5'(ROUNDS);

  present_state_e              fsm, fsm_nxt;
  logic [PRESENT_BLOCK_W-1:0]  st, t, sb_out, st_next, whitened;
  logic [PRESENT_KEY_W-1:0]    key, key_next;
  logic [4:0]                  rnd;
  logic [15:0][3:0]            nib_in, nib_out;
  logic                        load, step;

  key_addition u_round_add (
    .state_in  (st),
    .round_key (key[79:16]),
    .state_out (t)
  );

  split_0 u_split (
    .din (t),
    .nib (nib_in)
  );

  for (genvar n = 0; n < 16; n++) begin : g_sbox
    sbox u_sbox (
      .din  (nib_in[n]),
      .dout (nib_out[n])
    );
  end

  merge_0 u_merge (
    .nib  (nib_out),
    .dout (sb_out)
  );

  perm u_perm (
    .din  (sb_out),
    .dout (st_next)
  );

  present_key_update u_key_update (
    .key_in  (key),
    .rnd     (rnd),
    .key_out (key_next)
  );

  // Final whitening uses the round key left in the register after the last update.
  key_addition u_final_add (
    .state_in  (st),
    .round_key (key[79:16]),
    .state_out (whitened)
  );

  assign out_ct = out_valid ? whitened : '0;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // Next state and handshake outputs; DONE can retire and reload in one edge.
  always_comb begin
    fsm_nxt   = fsm;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    case (fsm)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          fsm_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (rnd == LAST_RND) fsm_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          if (in_valid) begin
            load    = 1'b1;
            fsm_nxt = RUN;
          end else begin
            fsm_nxt = IDLE;
          end
        end
      end
      default: fsm_nxt = IDLE;
    endcase
  end

  // Cipher state, key register and round counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st  <= '0;
      key <= '0;
      rnd <= '0;
    end else if (load) begin
      st  <= in_pt;
      key <= in_key;
      rnd <= 5'd1;
    end else if (step) begin
      st  <= st_next;
      key <= key_next;
      rnd <= rnd + 5'd1;
    end
  end

endmodule

// File: tb/tb_present_enc_core.sv
// Self-checking bench for present_enc_core against a behavioural PRESENT-80 model.
module tb_present_enc_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_pt = '0;
  logic [79:0] in_key = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_ct;

  int n_checks = 0;
  int n_errors = 0;

  present_enc_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pt     (in_pt),
    .in_key    (in_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ct    (out_ct)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Straight-line PRESENT-80 encryption from the cipher definition.
  function automatic logic [63:0] ref_enc(input logic [63:0] pt, input logic [79:0] k);
    int unsigned sb_tab [16] = '{12, 5, 6, 11, 9, 0, 10, 13, 3, 14, 15, 8, 4, 7, 1, 2};
    logic [63:0] s, p;
    logic [79:0] kk;
    s  = pt;
    kk = k;
    for (int r = 1; r <= 31; r++) begin
      s = s ^ kk[79:16];
      for (int n = 0; n < 16; n++) s[4*n +: 4] = 4'(sb_tab[s[4*n +: 4]]);
      p = '0;
      for (int i = 0; i < 64; i++) p[(i == 63) ? 63 : (i * 16) % 63] = s[i];
      s  = p;
      kk = {kk[18:0], kk[79:19]};
      kk[79:76] = 4'(sb_tab[kk[79:76]]);
      kk[19:15] = kk[19:15] ^ 5'(r);
    end
    return s ^ kk[79:16];
  endfunction

  // One block through the core: accept, wait for result, optional backpressure, retire.
  task automatic run_block(input string tag, input logic [63:0] pt, input logic [79:0] key,
                           input logic [63:0] exp, input int hold, input bit scramble);
    int cyc;
    logic [63:0] held;
    logic [95:0] rnd_bits;
    in_pt    = pt;
    in_key   = key;
    in_valid = 1'b1;
    check_val({tag, "_accept_rdy"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      if (scramble) begin
        rnd_bits = {$urandom(), $urandom(), $urandom()};
        in_pt    = {$urandom(), $urandom()};
        in_key   = rnd_bits[79:0];
        in_valid = 1'($urandom_range(0, 1));
      end
      if (in_ready) check_val({tag, "_rdy_in_run"}, in_ready, 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    check_val({tag, "_latency"}, cyc, 31);
    held = out_ct;
    for (int h = 0; h < hold; h++) begin
      tick();
      check_val({tag, "_hold_ct"}, out_ct, held);
      check_val({tag, "_hold_valid"}, out_valid, 1);
      check_val({tag, "_hold_rdy"}, in_ready, 0);
    end
    check_val({tag, "_ct"}, out_ct, exp);
    out_ready = 1'b1;
    #1;
    check_val({tag, "_rdy_retire"}, in_ready, 1);
    tick();
    out_ready = 1'b0;
    check_val({tag, "_retired"}, out_valid, 0);
    check_val({tag, "_ct_zero"}, out_ct, 0);
  endtask

  logic [63:0] vec_pt  [4] = '{64'h0, 64'h0, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF};
  logic [79:0] vec_key [4] = '{80'h0, 80'hFFFFFFFFFFFFFFFFFFFF, 80'h0, 80'hFFFFFFFFFFFFFFFFFFFF};
  logic [63:0] vec_ct  [4] = '{64'h5579C1387B228445, 64'hE72C46C0F5945049,
                               64'hA112FFC72F68417B, 64'h3333DCD3213210D2};

  initial begin
    int cyc, nacc, nret;
    int acc_cyc [4];
    logic [63:0] rpt;
    logic [95:0] rkey;
    bit acc, ret;

    #12;
    check_val("rst_valid", out_valid, 0);
    check_val("rst_ct", out_ct, 0);
    rst_n = 1'b1;
    tick();
    check_val("rst_rdy", in_ready, 1);
    check_val("rst_valid_after", out_valid, 0);

    // Known-answer vectors, last one with 10 cycles of backpressure.
    run_block("kat0", vec_pt[0], vec_key[0], vec_ct[0], 0, 0);
    run_block("kat1", vec_pt[1], vec_key[1], vec_ct[1], 0, 0);
    run_block("kat2", vec_pt[2], vec_key[2], vec_ct[2], 0, 0);
    run_block("kat3", vec_pt[3], vec_key[3], vec_ct[3], 10, 0);

    // Back-to-back with both handshakes held high.
    nacc = 0; nret = 0; cyc = 0;
    in_pt = vec_pt[0]; in_key = vec_key[0]; in_valid = 1'b1; out_ready = 1'b1;
    while (nret < 4 && cyc < 400) begin
      acc = in_valid && in_ready;
      ret = out_valid && out_ready;
      if (ret) begin
        check_val("b2b_ct", out_ct, vec_ct[nret]);
        nret++;
      end
      if (acc) begin
        acc_cyc[nacc] = cyc;
        nacc++;
      end
      tick();
      cyc++;
      if (acc) begin
        if (nacc < 4) begin
          in_pt  = vec_pt[nacc];
          in_key = vec_key[nacc];
        end else begin
          in_valid = 1'b0;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check_val("b2b_retired", nret, 4);
    check_val("b2b_accepted", nacc, 4);
    for (int i = 1; i < 4; i++) check_val("b2b_spacing", acc_cyc[i] - acc_cyc[i-1], 32);
    tick();

    // Reset during round 15.
    in_pt = '0; in_key = '0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (14) tick();
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_run_valid", out_valid, 0);
    check_val("rst_run_ct", out_ct, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_val("rst_run_rdy", in_ready, 1);

    // Reset while a ciphertext is waiting.
    in_pt = vec_pt[2]; in_key = vec_key[2]; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (33) tick();
    check_val("pre_rst_done_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check_val("rst_done_valid", out_valid, 0);
    check_val("rst_done_ct", out_ct, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check_val("rst_done_rdy", in_ready, 1);
    run_block("post_rst", 64'h0, 80'h0, 64'h5579C1387B228445, 0, 0);

    // Random blocks with inputs toggling while the core is busy.
    for (int b = 0; b < 8; b++) begin
      rpt  = {$urandom(), $urandom()};
      rkey = {$urandom(), $urandom(), $urandom()};
      run_block("rand", rpt, rkey[79:0], ref_enc(rpt, rkey[79:0]), $urandom_range(0, 3), 1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/present_enc_core.md
# present_enc_core

Iterative PRESENT-80 encryption engine: accepts a 64-bit plaintext and 80-bit key over a valid/ready handshake, runs one cipher round per clock, and returns the 64-bit ciphertext over a second valid/ready handshake. It is the round datapath and controller that instantiates the existing `key_addition`, `sbox`, `perm`, `split_0` and `merge_0` building blocks. It adds the on-the-fly key schedule and the round FSM.

## Interface
- `ROUNDS`, default 31: number of full rounds executed before final whitening; legal range 1..31; only 31 is standard PRESENT.
- `clk` input 1: sole clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: plaintext/key offered.
- `in_ready` output 1: core can accept a block this cycle.
- `in_pt` input 64: plaintext.
- `in_key` input 80: cipher key; bit 79 is MSB.
- `out_valid` output 1: ciphertext available.
- `out_ready` input 1: consumer accepts ciphertext.
- `out_ct` output 64: ciphertext; forced to 0 whenever `out_valid`=0.

## Operation
- Registers:
  - `st` (64): cipher state.
  - `key` (80): key register.
  - `rnd` (5): round counter.
  - `fsm`: one of IDLE, RUN, DONE.
- Round datapath:
  - `t = st ^ key[79:16]` (`key_addition`).
  - Apply the 16 parallel `sbox` instances over nibbles, via `split_0`/`merge_0`.
  - Apply `perm`.
  - Result is `st_next`.
- Key update for round counter value r:
  - Rotate left 61: `k' = {key[18:0], key[79:19]}`.
  - `k'[79:76] = sbox(k'[79:76])`.
  - `k'[19:15] ^= r`.
- IDLE:
  - `in_ready`=1.
  - On `in_valid && in_ready`: `st <= in_pt`, `key <= in_key`, `rnd <= 1`, go to RUN.
- RUN:
  - `in_ready`=0.
  - Each cycle: `st <= st_next`, `key <= key_update(key, rnd)`, `rnd <= rnd+1`.
  - When `rnd == ROUNDS`, this update is the last one and the FSM goes to DONE.
- DONE:
  - `out_valid`=1 and `out_ct = st ^ key[79:16]`, the final whitening with K(ROUNDS+1).
  - `st`, `key` and `out_ct` are held stable while `out_ready`=0.
- Back-to-back operation:
  - `in_ready = (fsm==IDLE) || (fsm==DONE && out_ready)`; this is a combinational path from `out_ready`.
  - In DONE with `out_ready`=1 and `in_valid`=1: the output retires and the new block loads in the same edge, going straight to RUN.
  - In DONE with `out_ready`=1 and `in_valid`=0: go to IDLE.
- `in_pt`/`in_key` are sampled only at the accept edge; changes during RUN/DONE are ignored.
- Round counter: 5-bit; the XOR uses the full 5-bit value (1..31); it never wraps within a block.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - fsm=IDLE; `st`, `key`, `rnd` = 0.
  - `out_valid`=0, `out_ct`=0, `in_ready`=1 (after reset deasserts).
- Reset mid-RUN or mid-DONE: the in-flight block is discarded; `out_valid` drops immediately and no ciphertext is emitted.
- Latency: with the accept at edge 0, rounds execute at edges 1..ROUNDS, and `out_valid` is high in the cycle after edge ROUNDS (31 cycles for default).
- Throughput:
  - One block per ROUNDS+1 cycles with `out_ready` tied high.
  - 32 cycles per block at default.
- `out_valid` never deasserts without a handshake except on reset.

## Structure
- Shared package `present_pkg`:
  - FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2).
  - `PRESENT_BLOCK_W`=64, `PRESENT_KEY_W`=80, `PRESENT_ROUNDS`=31.
- One sub-module: `present_key_update` (combinational, ports: key_in 80, rnd 5, key_out 80), instantiating one `sbox`.
- Top-level instantiates 16 `sbox`, one each of `key_addition` (round) and `perm`. Final whitening reuses a second `key_addition`.

## Test plan
- pt=0000000000000000, key=0 (80-bit) -> `out_ct`=5579C1387B228445, with `out_valid` rising exactly 31 cycles after accept.
- pt=0, key=FFFFFFFFFFFFFFFFFFFF -> E72C46C0F5945049; pt=FFFFFFFFFFFFFFFF, key=0 -> A112FFC72F68417B.
- pt=FFFFFFFFFFFFFFFF, key=FFFFFFFFFFFFFFFFFFFF with `out_ready`=0 for 10 cycles after `out_valid` -> 3333DCD3213210D2 held stable and `in_ready`=0 throughout; retires on the first `out_ready`=1 cycle.
- Back-to-back: `out_ready`=1 and `in_valid`=1 continuously, with the four vectors above in order -> four correct ciphertexts, accepts spaced exactly 32 cycles apart, no IDLE cycle between blocks.
- Assert `rst_n`=0 at round 15 of a block -> `out_valid`/`out_ct` go to 0 immediately and `in_ready`=1 after release. The next block (pt=0, key=0) yields 5579C1387B228445 and no stale output is ever emitted.
- Toggle `in_pt`/`in_key` randomly every cycle during RUN -> ciphertext matches the values captured at accept.
